masked_rand_buffer: RTL and testbench
=====================================

# masked_rand_buffer

Buffers fresh masking randomness from the free-running RNG core and hands it out, one 6-word bundle at a time, to the masked Kyber datapath over a valid/ready handshake. It sits directly downstream of the RNG core's r1..r6 outputs. Its job is to discard RNG start-up transients, stop any sample from reaching two consumers, and flag a consumer that reads when no randomness is available.

## Interface
Parameters:
- COEFF_SZ, 16, width of each random word
- DEPTH, 8, FIFO entries (power of 2, ≥2)
- WARMUP, 8, number of rng_en-high cycles discarded after reset before capture starts (≥1)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rng_en  in  1  RNG outputs are advancing this cycle (RNG enable)
- r1..r6  in  COEFF_SZ each  RNG words, sampled when rng_en=1
- flush  in  1  discard all buffered entries
- out_valid  out  1  out_data holds an unused bundle
- out_ready  in  1  consumer takes bundle this cycle
- out_data  out  6*COEFF_SZ  {r6,r5,r4,r3,r2,r1} of head entry
- level  out  $clog2(DEPTH)+1  entries currently stored
- armed  out  1  warm-up complete
- drop_cnt  out  16  saturating count of samples dropped due to full
- underflow_err  out  1  sticky: out_ready seen with out_valid=0

## Operation
- Reset values: out_valid=0, level=0, armed=0, drop_cnt=0, underflow_err=0, out_data=0 (mem contents unspecified, but out_data must be masked to 0 when out_valid=0).
- Warm-up: a counter counts cycles with rng_en=1. armed is set on the cycle the count reaches WARMUP and holds until rst. No capture occurs while armed=0.
- Push: when armed=1 and rng_en=1, write the {r6..r1} bundle if level<DEPTH, or if level==DEPTH and a pop happens in the same cycle. Otherwise drop the sample and increment drop_cnt (saturates at 16'hFFFF).
- Pop: out_valid && out_ready advances the read pointer. Each bundle is presented exactly once. The block never repeats a bundle.
- Simultaneous push+pop: level unchanged; both pointers advance.
- FIFO is first-word fall-through. out_data = mem[rd_ptr] and out_valid = (level!=0).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- flush: the next cycle has level=0 and out_valid=0. Any push or pop in the flush cycle is ignored; a sample arriving in that cycle is discarded without counting as a drop. armed is unaffected.
- underflow_err: set when out_ready=1 and out_valid=0; cleared only by rst. A flush cycle with out_ready=1 and out_valid=1 is not an underflow.
- rst mid-operation: all state returns to reset values and warm-up restarts from 0.

## Timing
- Capture latency: a sample with rng_en=1 at edge t (armed, not full) appears with out_valid=1 in the cycle after edge t.
- Pop takes effect at the edge. The next bundle is visible in the following cycle.
- With rng_en held high, the first captured sample is the (WARMUP+1)-th enabled sample after reset. armed rises after the WARMUP-th enabled edge.
- Sustained throughput: one bundle per cycle in and out. No bubbles at full with simultaneous pop.
- level, drop_cnt and underflow_err are registered and update on the edge following the event.

## Test plan
- Warm-up: rst, then rng_en=1 with r1 = cycle index 1,2,3…, out_ready=0. Required: armed rises after the 8th enabled edge. The first stored bundle has r1=9, and level increments by 1 per cycle thereafter.
- Fill/drop: continue with out_ready=0 until level=8. Required: out_valid=1, the bundle values stay frozen at r1=9, level holds at 8, and drop_cnt increments by 1 per cycle (5 extra cycles give drop_cnt=5).
- Full with pop: level=8, out_ready=1 for 1 cycle with rng_en=1. Required: out_data moves to r1=10, level stays 8, the new sample is stored at the tail, and drop_cnt is unchanged.
- Wrap/order: stream 20 bundles in with out_ready random at 50%. Required: the popped r1 sequence is strictly increasing with no duplicates, and gaps appear only where drops occurred (the gap total equals drop_cnt).
- Flush and underflow: with level=5, assert flush for 1 cycle with rng_en=0, then out_ready=1 for 1 cycle. Required: level=0, out_valid=0, out_data=0, underflow_err=1, and armed stays 1.
- Reset mid-run: assert rst for 1 cycle with level=3 and drop_cnt=2. Required: all outputs return to reset values, and 8 enabled cycles are needed again before armed=1.

Source files
------------

// File: rtl/masked_rand_buffer_if.sv
// Output handshake bundle between the randomness buffer and the masked datapath.
// The buffer side uses the master modport and the consumer uses the slave modport.
interface masked_rand_buffer_if #(
    parameter int COEFF_SZ = 16
);

    logic                    out_valid;
    logic                    out_ready;
    logic [6*COEFF_SZ-1:0]   out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/masked_rand_buffer.sv
// Buffers 6-word masking randomness bundles from the RNG core in a
// first-word fall-through FIFO. Warm-up samples are thrown away, every stored
// bundle is handed out exactly once, overflow samples are counted, and a read
// with nothing available raises a sticky error.
module masked_rand_buffer #(
    parameter int COEFF_SZ = 16,
    parameter int DEPTH    = 8,
    parameter int WARMUP   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rng_en,
    input  logic [COEFF_SZ-1:0]       r1,
    input  logic [COEFF_SZ-1:0]       r2,
    input  logic [COEFF_SZ-1:0]       r3,
    input  logic [COEFF_SZ-1:0]       r4,
    input  logic [COEFF_SZ-1:0]       r5,
    input  logic [COEFF_SZ-1:0]       r6,
    input  logic                      flush,
    masked_rand_buffer_if.master      out_bus,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      armed,
    output logic [15:0]               drop_cnt,
    output logic                      underflow_err
);

    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int WCW = $clog2(WARMUP + 1);
    localparam int BW  = 6 * COEFF_SZ;

    logic [BW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [WCW-1:0] warm_cnt;

    logic [BW-1:0]  in_bundle;
    logic           fifo_empty;
    logic           fifo_full;
    logic           do_pop;
    logic           want_push;
    logic           do_push;
    logic           do_drop;

    // Decode this cycle's push/pop/drop decisions. A flush cycle swallows both
    // sides of the FIFO, and a sample arriving then is not counted as a drop.
    always_comb begin
        in_bundle  = {r6, r5, r4, r3, r2, r1};
        fifo_empty = (level == '0);
        fifo_full  = (level == LW'(DEPTH));
        do_pop     = !fifo_empty && out_bus.out_ready && !flush;
        want_push  = armed && rng_en && !flush;
        do_push    = want_push && (!fifo_full || do_pop);
        do_drop    = want_push && fifo_full && !do_pop;
    end

    // First-word fall-through output; data is masked so stale memory never
    // leaks out while nothing valid is buffered.
    assign out_bus.out_valid = !fifo_empty;
    assign out_bus.out_data  = fifo_empty ? '0 : mem[rd_ptr];

    // Count enabled RNG cycles after reset and arm capture once the start-up
    // transient has passed; armed then holds until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= '0;
            armed    <= 1'b0;
        end else if (rng_en && !armed) begin
            warm_cnt <= warm_cnt + WCW'(1);
            if (warm_cnt == WCW'(WARMUP - 1)) begin
                armed <= 1'b1;
            end
        end
    end

    // Storage array has no reset; its contents are only observable through the
    // masked output once a bundle has actually been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_bundle;
        end
    end

    // Pointer and occupancy bookkeeping. Pointers wrap naturally modulo DEPTH;
    // a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LW'(1);
            end
        end
    end

    // Saturating count of armed samples lost because the FIFO was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 16'd0;
        end else if (do_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Sticky flag for a consumer reading while nothing is available.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_err <= 1'b0;
        end else if (out_bus.out_ready && fifo_empty) begin
            underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_masked_rand_buffer.sv
// Self-checking bench for masked_rand_buffer: directed phases from the
// behaviour description followed by a randomized run, all compared against a
// queue-based reference model.
module tb_masked_rand_buffer;

    localparam int COEFF_SZ = 16;
    localparam int DEPTH    = 8;
    localparam int WARMUP   = 8;
    localparam int BW       = 6 * COEFF_SZ;

    logic                  clk;
    logic                  rst;
    logic                  rng_en;
    logic [COEFF_SZ-1:0]   r1, r2, r3, r4, r5, r6;
    logic                  flush;
    logic [$clog2(DEPTH):0] level;
    logic                  armed;
    logic [15:0]           drop_cnt;
    logic                  underflow_err;

    masked_rand_buffer_if #(.COEFF_SZ(COEFF_SZ)) bus ();

    masked_rand_buffer #(
        .COEFF_SZ(COEFF_SZ),
        .DEPTH   (DEPTH),
        .WARMUP  (WARMUP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rng_en       (rng_en),
        .r1           (r1),
        .r2           (r2),
        .r3           (r3),
        .r4           (r4),
        .r5           (r5),
        .r6           (r6),
        .flush        (flush),
        .out_bus      (bus),
        .level        (level),
        .armed        (armed),
        .drop_cnt     (drop_cnt),
        .underflow_err(underflow_err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;

    // Reference model state: stored bundles in order, enabled-cycle count,
    // armed flag, drop counter and sticky underflow.
    logic [BW-1:0] mdlQ[$];
    int            mdlEnCnt = 0;
    bit            mdlArmed = 0;
    int            mdlDrop  = 0;
    bit            mdlUf    = 0;
    logic [15:0]   r1Next   = 16'd1;

    task automatic checkOutput(input string tag, input logic [BW-1:0] observed,
                               input logic [BW-1:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        bit valid;
        bit pop;
        if (rst) begin
            mdlQ.delete();
            mdlEnCnt = 0;
            mdlArmed = 0;
            mdlDrop  = 0;
            mdlUf    = 0;
        end else begin
            valid = (mdlQ.size() != 0);
            if (bus.out_ready && !valid) mdlUf = 1;
            if (flush) begin
                mdlQ.delete();
            end else begin
                pop = valid && bus.out_ready;
                if (pop) void'(mdlQ.pop_front());
                if (mdlArmed && rng_en) begin
                    if (mdlQ.size() < DEPTH) mdlQ.push_back({r6, r5, r4, r3, r2, r1});
                    else if (mdlDrop < 65535) mdlDrop++;
                end
            end
            if (rng_en && !mdlArmed) begin
                mdlEnCnt++;
                if (mdlEnCnt == WARMUP) mdlArmed = 1;
            end
        end
    endtask

    task automatic compareAll();
        logic [BW-1:0] expData;
        expData = (mdlQ.size() != 0) ? mdlQ[0] : '0;
        checkOutput("out_valid", BW'(bus.out_valid), BW'(mdlQ.size() != 0));
        checkOutput("out_data", bus.out_data, expData);
        checkOutput("level", BW'(level), BW'(mdlQ.size()));
        checkOutput("armed", BW'(armed), BW'(mdlArmed));
        checkOutput("drop_cnt", BW'(drop_cnt), BW'(mdlDrop));
        checkOutput("underflow_err", BW'(underflow_err), BW'(mdlUf));
    endtask

    // Drive one cycle of inputs, step the model at the edge and compare after it.
    task automatic applyStimulus(input logic iRst, input logic iEn,
                                 input logic iFlush, input logic iReady);
        @(negedge clk);
        rst           = iRst;
        rng_en        = iEn;
        flush         = iFlush;
        bus.out_ready = iReady;
        r1 = iEn ? r1Next : 16'($urandom);
        if (iEn) r1Next = r1Next + 16'd1;
        r2 = 16'($urandom);
        r3 = 16'($urandom);
        r4 = 16'($urandom);
        r5 = 16'($urandom);
        r6 = 16'($urandom);
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    initial begin
        rst = 1'b1; rng_en = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
        r1 = '0; r2 = '0; r3 = '0; r4 = '0; r5 = '0; r6 = '0;

        // Reset state.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("rst_out_data", bus.out_data, '0);
        checkOutput("rst_level", BW'(level), BW'(0));

        // Warm-up: eight enabled edges arm the block without capturing.
        r1Next = 16'd1;
        for (int i = 0; i < WARMUP; i++) begin
            applyStimulus(0, 1, 0, 0);
        end
        checkOutput("warm_armed", BW'(armed), BW'(1));
        checkOutput("warm_level", BW'(level), BW'(0));

        // Fill to DEPTH; the head bundle is the ninth sample.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 1, 0, 0);
        end
        checkOutput("fill_level", BW'(level), BW'(DEPTH));
        checkOutput("fill_head_r1", BW'(bus.out_data[15:0]), BW'(9));

        // Five more samples are dropped while full.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0);
        end
        checkOutput("drop_cnt5", BW'(drop_cnt), BW'(5));
        checkOutput("drop_head_r1", BW'(bus.out_data[15:0]), BW'(9));

        // Pop while full with a concurrent push: no drop, level holds.
        applyStimulus(0, 1, 0, 1);
        checkOutput("fullpop_head_r1", BW'(bus.out_data[15:0]), BW'(10));
        checkOutput("fullpop_level", BW'(level), BW'(DEPTH));
        checkOutput("fullpop_drop", BW'(drop_cnt), BW'(5));

        // Wrap/order: stream with a random consumer.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 0, 1'($urandom_range(0, 1)));
        end

        // Drain completely, then build a level of five.
        for (int i = 0; i < 2 * DEPTH + 4; i++) begin
            if (mdlQ.size() == 0) break;
            applyStimulus(0, 0, 0, 1);
        end
        checkOutput("drain_level", BW'(level), BW'(0));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 0, 0);
        end
        checkOutput("pre_flush_level", BW'(level), BW'(5));
        checkOutput("pre_flush_uf", BW'(underflow_err), BW'(0));

        // Flush, then read from an empty buffer.
        applyStimulus(0, 0, 1, 0);
        checkOutput("flush_level", BW'(level), BW'(0));
        checkOutput("flush_valid", BW'(bus.out_valid), BW'(0));
        applyStimulus(0, 0, 0, 1);
        checkOutput("uf_set", BW'(underflow_err), BW'(1));
        checkOutput("uf_data", bus.out_data, '0);
        checkOutput("flush_armed", BW'(armed), BW'(1));

        // Reset mid-run restarts warm-up.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0);
        end
        applyStimulus(1, 0, 0, 0);
        checkOutput("midrst_level", BW'(level), BW'(0));
        checkOutput("midrst_armed", BW'(armed), BW'(0));
        checkOutput("midrst_drop", BW'(drop_cnt), BW'(0));
        checkOutput("midrst_uf", BW'(underflow_err), BW'(0));
        for (int i = 0; i < WARMUP - 1; i++) begin
            applyStimulus(0, 1, 0, 0);
        end
        checkOutput("rewarm_not_armed", BW'(armed), BW'(0));
        applyStimulus(0, 1, 0, 0);
        checkOutput("rewarm_armed", BW'(armed), BW'(1));

        // Randomized run with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 63) == 0),
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
